mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, BUSY cycles without bus_ack_i before abort (1..255).
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Ports (name, direction, width, meaning), SHALL be exactly:
  clk  in  1  clock, rising edge
  arst  in  1  async active-high reset
  valid_i  in  1  execute-stage result valid
  inst_i  in  32  instruction, used to decode the access type
  reg_w_ena_i  in  1  register-write enable from execute
  reg_waddr_i  in  5  destination register
  reg_w_data_i  in  32  ALU result, passed through for non-memory instructions
  mem_addr_i  in  32  effective load/store address
  mem_wdata_i  in  32  store data, rs2
  bus_req_o  out  1  data-bus request
  bus_we_o  out  1  1=write
  bus_addr_o  out  32  word-aligned address
  bus_wdata_o  out  32  lane-replicated store data
  bus_be_o  out  4  byte enables
  bus_ack_i  in  1  bus completion; read data valid in the same cycle
  bus_rdata_i  in  32  read word
  valid_o  out  1  result valid toward write-back
  reg_w_ena_o  out  1  write-back enable
  reg_waddr_o  out  5  write-back register
  reg_w_data_o  out  32  write-back data
  hold_flag_o  out  1  stall request to ctrl
  misalign_o  out  1  one-cycle misaligned-access pulse
  bus_err_o  out  1  one-cycle bus-timeout pulse

Function
REQ-004 Decode: inst_i[6:0]=0000011 is a load; 0100011 is a store; funct3=inst_i[14:12].
REQ-005 Loads SHALL support LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SHALL support SB 000, SH 001, SW 010.
REQ-006 A load/store opcode with any other funct3 SHALL be illegal: no bus access, DONE next cycle, reg_w_ena_o=0.
REQ-007 FSM SHALL have states IDLE, BUSY and DONE; an input is accepted when valid_i=1 in IDLE or DONE.
REQ-008 An accepted non-memory instruction SHALL appear on valid_o/reg_* one cycle later, registered and unchanged; the FSM stays in or returns to IDLE.
REQ-009 An accepted memory instruction SHALL latch all fields and enter BUSY; hold_flag_o=(state==BUSY); inputs SHALL be ignored in BUSY.
REQ-010 In BUSY, bus_req_o=1 and bus_we_o, bus_addr_o, bus_wdata_o and bus_be_o SHALL be stable; bus_addr_o={addr[31:2],2'b00}.
REQ-011 Store lanes SHALL be: SB be=0001<<addr[1:0] with data byte replicated ×4; SH be=0011<<{addr[1],0} with data half replicated ×2; SW be=1111.
REQ-012 On bus_ack_i in BUSY: bus_req_o SHALL drop next cycle and the FSM SHALL enter DONE.
REQ-013 Load data SHALL be the addressed lane shifted to bit 0, sign-extended for LB/LH, zero-extended for LBU/LHU, and registered.
REQ-014 DONE SHALL last one cycle: valid_o=1; a load sets reg_w_ena_o=reg_w_ena_i, while a store sets reg_w_ena_o=0.
REQ-015 A BUSY cycle counter SHALL abort at TIMEOUT cycles: req drops, DONE is entered with bus_err_o=1 and reg_w_ena_o=0.
REQ-016 If bus_ack_i arrives in the timeout cycle, ack SHALL win and bus_err_o SHALL stay 0.
REQ-017 When valid_o=0, reg_w_ena_o SHALL be 0.

Reset
REQ-018 arst SHALL force IDLE immediately, including mid-BUSY, and zero the counter.
REQ-019 During reset every output SHALL be 0; bus_req_o SHALL drop in the same cycle, without waiting for ack.

Configuration
REQ-020 With MEM_MISALIGN_CHK_EN defined, LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]≠0 SHALL issue no bus request: DONE next cycle, misalign_o=1, reg_w_ena_o=0.
REQ-021 Without MEM_MISALIGN_CHK_EN, misaligned halfword/word accesses SHALL clear offending address bits (halfword bit0; word bits 1:0) and proceed normally; misalign_o is tied 0.

Verification
REQ-022 ADD result 0x1234 to x5, valid_i=1 -> next cycle valid_o=1, reg_waddr_o=5, reg_w_data_o=0x1234, no bus_req_o.
REQ-023 SB addr 0x103, data 0xA5 -> bus_addr_o=0x100, bus_be_o=1000, bus_wdata_o=0xA5A5A5A5, hold=1 until ack; after ack, valid_o with reg_w_ena_o=0.
REQ-024 LB addr 0x102, rdata 0x00800000, ack after 3 wait cycles -> reg_w_data_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-025 LW, no ack, TIMEOUT=4 -> req drops after 4 BUSY cycles, bus_err_o pulses, reg_w_ena_o=0; a variant with ack in the 4th cycle -> normal completion.
REQ-026 LW addr 0x102: with the macro -> misalign_o=1 and no request; without it -> bus_addr_o=0x100 and a normal load.
REQ-027 arst asserted mid-BUSY -> bus_req_o=0 and hold_flag_o=0 immediately; after release, an ADD completes in one cycle.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: load/store unit sitting between execute and write-back.
// Non-memory results pass through one register stage. Loads and stores
// run a single-beat data-bus transaction through an IDLE/BUSY/DONE FSM
// with a BUSY-cycle timeout.
// Optional feature macro: MEM_MISALIGN_CHK_EN. When defined, misaligned
// halfword/word accesses are rejected and reported on misalign_o. When
// undefined, the offending low address bits are cleared and the access
// proceeds.
//
// Bus handshake: bus_req_o is high for every BUSY cycle and the command
// fields (we/addr/wdata/be) hold steady while it is high. A transfer
// completes in the cycle bus_ack_i is sampled high with bus_req_o high,
// and read data is taken from bus_rdata_i in that same cycle. Inputs from
// execute are accepted when valid_i is high and the FSM is not BUSY.
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        valid_i,
  input  logic [31:0] inst_i,
  input  logic        reg_w_ena_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic [31:0] reg_w_data_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        valid_o,
  output logic        reg_w_ena_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_w_data_o,
  output logic        hold_flag_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Decode of the incoming instruction
  logic       is_load, is_store, is_mem, legal, mis_in, go_bus, accept;
  logic [2:0] f3;
  logic [31:0] addr_al;

  // Latched memory-access fields, held for the whole transaction
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wena_q;
  logic [4:0]  waddr_q;
  logic [7:0]  cnt_q;
  logic        timeout_hit;

  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [31:0] sh_c;
  logic [31:0] ld_ext;

  logic        valid_q, reg_wena_q, err_q;
  logic [4:0]  reg_waddr_q;
  logic [31:0] reg_data_q;

  // Bits of the instruction word this unit never looks at
  logic unused_ok;
  assign unused_ok = &{1'b0, inst_i[31:15], inst_i[11:7]};

  // Access-type decode and address alignment
  always_comb begin
    f3       = inst_i[14:12];
    is_load  = (inst_i[6:0] == 7'b0000011);
    is_store = (inst_i[6:0] == 7'b0100011);
    is_mem   = is_load | is_store;
    legal    = 1'b0;
    if (is_load)
      legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
              (f3 == 3'b100) || (f3 == 3'b101);
    else if (is_store)
      legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
`ifdef MEM_MISALIGN_CHK_EN
    mis_in = legal && (((f3[1:0] == 2'b01) && mem_addr_i[0]) ||
                       ((f3[1:0] == 2'b10) && (mem_addr_i[1:0] != 2'b00)));
`else
    mis_in = 1'b0;
`endif
    // Halfword ignores bit 0, word ignores bits 1:0
    addr_al = mem_addr_i;
    if (f3[1:0] == 2'b01)
      addr_al[0] = 1'b0;
    else if (f3[1:0] == 2'b10)
      addr_al[1:0] = 2'b00;
    accept = valid_i && (state_q != BUSY);
    go_bus = accept && is_mem && legal && !mis_in;
  end

  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  // FSM state register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept && is_mem)
          state_d = go_bus ? BUSY : DONE;
      end
      BUSY: begin
        if (bus_ack_i || timeout_hit) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch access fields on acceptance; count BUSY cycles
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ld_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wena_q  <= 1'b0;
      waddr_q <= 5'd0;
      cnt_q   <= 8'd0;
    end else begin
      if (accept && is_mem) begin
        ld_q    <= is_load;
        f3_q    <= f3;
        addr_q  <= addr_al;
        wdata_q <= mem_wdata_i;
        wena_q  <= reg_w_ena_i;
        waddr_q <= reg_waddr_i;
      end
      cnt_q <= (state_q == BUSY) ? cnt_q + 8'd1 : 8'd0;
    end
  end

  // Byte lanes and replicated store data from the latched access
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        be_c = 4'b0001 << addr_q[1:0];
        wd_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c = 4'b0011 << {addr_q[1], 1'b0};
        wd_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = wdata_q;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    sh_c = bus_rdata_i >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{sh_c[7]}}, sh_c[7:0]};
      3'b001:  ld_ext = {{16{sh_c[15]}}, sh_c[15:0]};
      3'b100:  ld_ext = {24'h0, sh_c[7:0]};
      3'b101:  ld_ext = {16'h0, sh_c[15:0]};
      default: ld_ext = sh_c;
    endcase
  end

  assign hold_flag_o = (state_q == BUSY);
  assign bus_req_o   = hold_flag_o;
  assign bus_we_o    = hold_flag_o && !ld_q;
  assign bus_addr_o  = hold_flag_o ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_be_o    = hold_flag_o ? be_c : 4'b0000;
  assign bus_wdata_o = bus_we_o ? wd_c : 32'h0;

  // Write-back result register: pass-through, completion, abort
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q     <= 1'b0;
      reg_wena_q  <= 1'b0;
      reg_waddr_q <= 5'd0;
      reg_data_q  <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      reg_wena_q <= 1'b0;
      err_q      <= 1'b0;
      if (state_q == BUSY) begin
        if (bus_ack_i) begin
          valid_q     <= 1'b1;
          reg_wena_q  <= ld_q & wena_q;
          reg_waddr_q <= waddr_q;
          reg_data_q  <= ld_q ? ld_ext : 32'h0;
        end else if (timeout_hit) begin
          valid_q     <= 1'b1;
          err_q       <= 1'b1;
          reg_waddr_q <= waddr_q;
          reg_data_q  <= 32'h0;
        end
      end else if (accept) begin
        if (!is_mem) begin
          valid_q     <= 1'b1;
          reg_wena_q  <= reg_w_ena_i;
          reg_waddr_q <= reg_waddr_i;
          reg_data_q  <= reg_w_data_i;
        end else if (!go_bus) begin
          valid_q     <= 1'b1;
          reg_waddr_q <= reg_waddr_i;
          reg_data_q  <= 32'h0;
        end
      end
    end
  end

`ifdef MEM_MISALIGN_CHK_EN
  logic mis_q;
  // One-cycle pulse accompanying a rejected misaligned access
  always_ff @(posedge clk or posedge arst) begin
    if (arst) mis_q <= 1'b0;
    else      mis_q <= accept && mis_in;
  end
  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign valid_o      = valid_q;
  assign reg_w_ena_o  = reg_wena_q;
  assign reg_waddr_o  = reg_waddr_q;
  assign reg_w_data_o = reg_data_q;
  assign bus_err_o    = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a vector table of single loads/stores
// plus hand-written sequences for pass-through, timeout, late ack and
// reset during a bus transaction.
module tb_mem_access;

  logic        clk, arst, valid_i, reg_w_ena_i, bus_ack_i;
  logic [31:0] inst_i, reg_w_data_i, mem_addr_i, mem_wdata_i, bus_rdata_i;
  logic [4:0]  reg_waddr_i;
  logic        bus_req_o, bus_we_o, valid_o, reg_w_ena_o, hold_flag_o, misalign_o, bus_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, reg_w_data_o;
  logic [3:0]  bus_be_o;
  logic [4:0]  reg_waddr_o;

  int total = 0;
  int bad   = 0;

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .arst(arst), .valid_i(valid_i), .inst_i(inst_i),
    .reg_w_ena_i(reg_w_ena_i), .reg_waddr_i(reg_waddr_i), .reg_w_data_i(reg_w_data_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .valid_o(valid_o), .reg_w_ena_o(reg_w_ena_o),
    .reg_waddr_o(reg_waddr_o), .reg_w_data_o(reg_w_data_o), .hold_flag_o(hold_flag_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        exp_bus;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_bwdata;
    logic [31:0] exp_data;
    logic        exp_wena;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic st, input logic [2:0] f3);
    mk_inst = {17'h0, f3, 5'd3, (st ? 7'b0100011 : 7'b0000011)};
  endfunction

  // Driver: present one instruction for exactly one cycle
  task automatic issue(input logic [31:0] inst, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] data);
    @(negedge clk);
    valid_i      = 1'b1;
    inst_i       = inst;
    mem_addr_i   = addr;
    mem_wdata_i  = wdata;
    reg_w_data_i = data;
    reg_waddr_i  = 5'd7;
    reg_w_ena_i  = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    issue(mk_inst(v.st, v.f3), v.addr, v.wdata, 32'h0);
    if (v.exp_bus) begin
      chk({v.name, " req"}, {31'h0, bus_req_o}, 32'h1);
      chk({v.name, " hold"}, {31'h0, hold_flag_o}, 32'h1);
      chk({v.name, " we"}, {31'h0, bus_we_o}, {31'h0, v.st});
      chk({v.name, " baddr"}, bus_addr_o, v.exp_baddr);
      chk({v.name, " be"}, {28'h0, bus_be_o}, {28'h0, v.exp_be});
      if (v.st) chk({v.name, " bwdata"}, bus_wdata_o, v.exp_bwdata);
      for (int w = 0; w < v.waits; w++) @(negedge clk);
      chk({v.name, " req held"}, {31'h0, bus_req_o}, 32'h1);
      bus_ack_i   = 1'b1;
      bus_rdata_i = v.rdata;
      @(negedge clk);
      bus_ack_i   = 1'b0;
      bus_rdata_i = 32'h0;
      chk({v.name, " req drop"}, {31'h0, bus_req_o}, 32'h0);
      chk({v.name, " data"}, reg_w_data_o, v.exp_data);
    end else begin
      chk({v.name, " no req"}, {31'h0, bus_req_o}, 32'h0);
    end
    chk({v.name, " valid"}, {31'h0, valid_o}, 32'h1);
    chk({v.name, " wena"}, {31'h0, reg_w_ena_o}, {31'h0, v.exp_wena});
    chk({v.name, " mis"}, {31'h0, misalign_o}, {31'h0, v.exp_mis});
    chk({v.name, " err"}, {31'h0, bus_err_o}, 32'h0);
    chk({v.name, " hold off"}, {31'h0, hold_flag_o}, 32'h0);
    @(negedge clk);
    chk({v.name, " done 1cyc"}, {31'h0, valid_o}, 32'h0);
  endtask

  initial begin
    arst = 1'b1; valid_i = 1'b0; inst_i = 32'h0; reg_w_ena_i = 1'b0;
    reg_waddr_i = 5'd0; reg_w_data_i = 32'h0; mem_addr_i = 32'h0;
    mem_wdata_i = 32'h0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;

    //             name      st    f3      addr         wdata         rdata         w  bus   baddr         be       bwdata        data          wena  mis
    vecs[0]  = '{"sb103",   1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{"sb100",   1'b1, 3'b000, 32'h100, 32'h1234563C, 32'h0,        1, 1'b1, 32'h100, 4'b0001, 32'h3C3C3C3C, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{"sh102",   1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0,        0, 1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{"sw104",   1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0,        2, 1'b1, 32'h104, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{"lb102",   1'b0, 3'b000, 32'h102, 32'h0,        32'h00800000, 3, 1'b1, 32'h100, 4'b0100, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0};
    vecs[5]  = '{"lbu102",  1'b0, 3'b100, 32'h102, 32'h0,        32'h00800000, 3, 1'b1, 32'h100, 4'b0100, 32'h0,        32'h00000080, 1'b1, 1'b0};
    vecs[6]  = '{"lb101",   1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 1'b1, 32'h100, 4'b0010, 32'h0,        32'h0000007F, 1'b1, 1'b0};
    vecs[7]  = '{"lh102",   1'b0, 3'b001, 32'h102, 32'h0,        32'h80010000, 1, 1'b1, 32'h100, 4'b1100, 32'h0,        32'hFFFF8001, 1'b1, 1'b0};
    vecs[8]  = '{"lhu102",  1'b0, 3'b101, 32'h102, 32'h0,        32'h80010000, 0, 1'b1, 32'h100, 4'b1100, 32'h0,        32'h00008001, 1'b1, 1'b0};
    vecs[9]  = '{"lw200",   1'b0, 3'b010, 32'h200, 32'h0,        32'hDEADBEEF, 0, 1'b1, 32'h200, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[10] = '{"ill_st",  1'b1, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b0, 1'b0};
`ifdef MEM_MISALIGN_CHK_EN
    vecs[11] = '{"lw102",   1'b0, 3'b010, 32'h102, 32'h0,        32'h11223344, 0, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b0, 1'b1};
`else
    vecs[11] = '{"lw102",   1'b0, 3'b010, 32'h102, 32'h0,        32'h11223344, 0, 1'b1, 32'h100, 4'b1111, 32'h0,        32'h11223344, 1'b1, 1'b0};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst req", {31'h0, bus_req_o}, 32'h0);
    chk("rst valid", {31'h0, valid_o}, 32'h0);
    chk("rst hold", {31'h0, hold_flag_o}, 32'h0);
    chk("rst data", reg_w_data_o, 32'h0);
    chk("rst err_mis", {30'h0, bus_err_o, misalign_o}, 32'h0);
    arst = 1'b0;

    // Non-memory pass-through: ADD result to x5
    @(negedge clk);
    valid_i = 1'b1; inst_i = 32'h00000033; reg_waddr_i = 5'd5;
    reg_w_data_i = 32'h1234; reg_w_ena_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    chk("add valid", {31'h0, valid_o}, 32'h1);
    chk("add waddr", {27'h0, reg_waddr_o}, 32'd5);
    chk("add data", reg_w_data_o, 32'h1234);
    chk("add wena", {31'h0, reg_w_ena_o}, 32'h1);
    chk("add no req", {31'h0, bus_req_o}, 32'h0);
    @(negedge clk);
    chk("add 1cyc", {31'h0, valid_o | reg_w_ena_o}, 32'h0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Timeout: LW with no ack, TIMEOUT=4
    issue(mk_inst(1'b0, 3'b010), 32'h300, 32'h0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      chk("to req", {31'h0, bus_req_o}, 32'h1);
      @(negedge clk);
    end
    chk("to req drop", {31'h0, bus_req_o}, 32'h0);
    chk("to err", {31'h0, bus_err_o}, 32'h1);
    chk("to valid", {31'h0, valid_o}, 32'h1);
    chk("to wena", {31'h0, reg_w_ena_o}, 32'h0);
    @(negedge clk);
    chk("to err pulse", {31'h0, bus_err_o}, 32'h0);

    // Ack in the timeout cycle wins
    issue(mk_inst(1'b0, 3'b010), 32'h300, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("late req", {31'h0, bus_req_o}, 32'h1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0BADF00D;
    @(negedge clk);
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    chk("late err", {31'h0, bus_err_o}, 32'h0);
    chk("late valid", {31'h0, valid_o}, 32'h1);
    chk("late wena", {31'h0, reg_w_ena_o}, 32'h1);
    chk("late data", reg_w_data_o, 32'h0BADF00D);

    // Reset in the middle of BUSY
    issue(mk_inst(1'b0, 3'b010), 32'h400, 32'h0, 32'h0);
    @(negedge clk);
    chk("mid req", {31'h0, bus_req_o}, 32'h1);
    arst = 1'b1;
    #1;
    chk("mid rst req", {31'h0, bus_req_o}, 32'h0);
    chk("mid rst hold", {31'h0, hold_flag_o}, 32'h0);
    chk("mid rst addr", bus_addr_o, 32'h0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    valid_i = 1'b1; inst_i = 32'h00000033; reg_waddr_i = 5'd9;
    reg_w_data_i = 32'h55AA; reg_w_ena_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    chk("post rst valid", {31'h0, valid_o}, 32'h1);
    chk("post rst data", reg_w_data_o, 32'h55AA);
    chk("post rst waddr", {27'h0, reg_waddr_o}, 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
